// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB-first, optional parity, stop bit.
// Each bit is held for a latched, programmable number of clock cycles.
module uart_tx (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] P_DATA,
    input  logic       Data_Valid,
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
    input  logic [5:0] prescale,
    output logic       TX_OUT,
    output logic       Busy
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e      state_q;
    logic [7:0]  data_q;
    logic        par_en_q;
    logic        par_typ_q;
    logic [5:0]  presc_q;
    logic [5:0]  cnt_q;
    logic [2:0]  bit_idx_q;
    logic        tx_out_q;
    logic        busy_q;

    logic        bit_end;
    logic        parity_bit;

    assign bit_end    = (cnt_q == presc_q - 6'd1);
    assign parity_bit = par_typ_q ? ~^data_q : ^data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            data_q    <= 8'd0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            presc_q   <= 6'd0;
            cnt_q     <= 6'd0;
            bit_idx_q <= 3'd0;
            tx_out_q  <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    tx_out_q <= 1'b1;
                    busy_q   <= 1'b0;
                    if (Data_Valid) begin
                        data_q    <= P_DATA;
                        par_en_q  <= PAR_EN;
                        par_typ_q <= PAR_TYP;
                        // A prescale of 0 would never reach a bit boundary.
                        presc_q   <= (prescale == 6'd0) ? 6'd1 : prescale;
                        cnt_q     <= 6'd0;
                        bit_idx_q <= 3'd0;
                        tx_out_q  <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= StStart;
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        cnt_q     <= 6'd0;
                        bit_idx_q <= 3'd0;
                        tx_out_q  <= data_q[0];
                        state_q   <= StData;
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                StData: begin
                    if (bit_end) begin
                        cnt_q <= 6'd0;
                        if (bit_idx_q == 3'd7) begin
                            if (par_en_q) begin
                                tx_out_q <= parity_bit;
                                state_q  <= StParity;
                            end else begin
                                tx_out_q <= 1'b1;
                                state_q  <= StStop;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_out_q  <= data_q[bit_idx_q + 3'd1];
                        end
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                StParity: begin
                    if (bit_end) begin
                        cnt_q    <= 6'd0;
                        tx_out_q <= 1'b1;
                        state_q  <= StStop;
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                StStop: begin
                    if (bit_end) begin
                        cnt_q    <= 6'd0;
                        tx_out_q <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    tx_out_q <= 1'b1;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign TX_OUT = tx_out_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx; outputs are sampled on the falling edge.
module tb_uart_tx;

    logic       clk;
    logic       rst;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] prescale;
    logic       TX_OUT;
    logic       Busy;

    int n_cmp = 0;
    int n_err = 0;

    uart_tx dut (
        .clk        (clk),
        .rst        (rst),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .prescale   (prescale),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b required %b", tag, obs, exp);
        end
    endtask

    // Drive a request at a falling edge; the next rising edge accepts it.
    task automatic request(input logic [7:0] d, input logic pe, input logic pt,
                           input logic [5:0] p);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        prescale   = p;
        Data_Valid = 1'b1;
        @(negedge clk);
    endtask

    // Called half a cycle after the accepting edge; seq[0] is the first bit on the line.
    // Ends at the falling edge after Busy should have dropped, checking the idle level.
    task automatic check_frame(input string name, input logic [10:0] seq, input int nbits,
                               input int p, input logic keep_valid, input logic disturb);
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < p; c++) begin
                if (!keep_valid) Data_Valid = 1'b0;
                if (disturb && b == 4 && c == 0) begin
                    P_DATA     = ~P_DATA;
                    prescale   = 6'd9;
                    Data_Valid = 1'b1;
                end
                chk($sformatf("%s tx bit%0d cyc%0d", name, b, c), TX_OUT, seq[b]);
                chk($sformatf("%s busy bit%0d cyc%0d", name, b, c), Busy, 1'b1);
                @(negedge clk);
            end
        end
        chk($sformatf("%s idle tx", name), TX_OUT, 1'b1);
        chk($sformatf("%s idle busy", name), Busy, 1'b0);
    endtask

    initial begin
        rst        = 1'b0;
        P_DATA     = 8'h00;
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        prescale   = 6'd0;
        #12;
        chk("reset tx", TX_OUT, 1'b1);
        chk("reset busy", Busy, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("idle tx", TX_OUT, 1'b1);
        chk("idle busy", Busy, 1'b0);

        // Reset in the middle of DATA bit 3 of an all-zero byte.
        request(8'h00, 1'b0, 1'b0, 6'd4);
        Data_Valid = 1'b0;
        repeat (18) @(negedge clk);
        chk("pre-reset tx", TX_OUT, 1'b0);
        chk("pre-reset busy", Busy, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("mid-frame reset tx", TX_OUT, 1'b1);
        chk("mid-frame reset busy", Busy, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post-reset busy", Busy, 1'b0);
        request(8'h0F, 1'b0, 1'b0, 6'd4);
        check_frame("after reset 0x0F", 11'b0_1_00001111_0, 10, 4, 1'b0, 1'b0);

        // 0xA5 has four ones: even parity 0, odd parity 1.
        request(8'hA5, 1'b1, 1'b0, 6'd8);
        check_frame("even 0xA5", 11'b1_0_10100101_0, 11, 8, 1'b0, 1'b0);
        @(negedge clk);
        request(8'hA5, 1'b1, 1'b1, 6'd8);
        check_frame("odd 0xA5", 11'b1_1_10100101_0, 11, 8, 1'b0, 1'b0);

        @(negedge clk);
        request(8'h80, 1'b0, 1'b0, 6'd1);
        check_frame("0x80 p1", 11'b0_1_10000000_0, 10, 1, 1'b0, 1'b0);

        // prescale=0 acts as 1; mid-frame data change and valid pulse are ignored.
        @(negedge clk);
        request(8'h3C, 1'b0, 1'b0, 6'd0);
        check_frame("0x3C p0", 11'b0_1_00111100_0, 10, 1, 1'b0, 1'b1);
        Data_Valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("dropped pulse busy", Busy, 1'b0);
            chk("dropped pulse tx", TX_OUT, 1'b1);
        end

        // Held Data_Valid: frames repeat with exactly one idle cycle between them.
        request(8'h55, 1'b0, 1'b0, 6'd16);
        check_frame("cont 0x55 #1", 11'b0_1_01010101_0, 10, 16, 1'b1, 1'b0);
        @(negedge clk);
        check_frame("cont 0x55 #2", 11'b0_1_01010101_0, 10, 16, 1'b1, 1'b0);
        Data_Valid = 1'b0;
        @(negedge clk);
        chk("after cont busy", Busy, 1'b0);
        chk("after cont tx", TX_OUT, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter, the transmit-side counterpart of the receive FSM. It accepts one parallel byte per handshake and serializes it LSB-first onto a single line. The frame is a start bit, 8 data bits, an optional parity bit and a stop bit, and each bit lasts a programmable number of clock cycles. It sits in the same clock domain as the receive path and shares its prescale configuration.

## Interface
- No parameters. Data width is fixed at 8 and the prescale field at 6 bits.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- P_DATA  in  8  byte to send; sampled on acceptance.
- Data_Valid  in  1  request to send P_DATA; honoured only while Busy=0.
- PAR_EN  in  1  1 inserts a parity bit; sampled on acceptance.
- PAR_TYP  in  1  0 = even, 1 = odd; sampled on acceptance.
- prescale  in  6  clock cycles per bit; sampled on acceptance; 0 is treated as 1.
- TX_OUT  out  1  serial line; registered; idles at 1.
- Busy  out  1  registered; high for the whole frame.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_OUT=1, Busy=0.
  - If Data_Valid=1 at a clock edge, latch P_DATA, PAR_EN, PAR_TYP and prescale, then go to START.
  - Data_Valid is ignored in every other state. Inputs changing mid-frame have no effect.
- START: TX_OUT=0 for one bit period, then go to DATA.
- DATA:
  - TX_OUT = latched data[bit_idx], with bit_idx counting 0..7 (LSB first).
  - Each bit is held one bit period.
  - After bit 7, go to PARITY if latched PAR_EN=1, else go to STOP.
- PARITY:
  - TX_OUT = ^data when even, ~^data when odd.
  - Held one bit period, then go to STOP.
- STOP: TX_OUT=1 for one bit period, then go to IDLE.
- Bit period:
  - A 6-bit cycle counter runs 0..P-1, where P = latched prescale (P=1 if prescale=0).
  - The counter clears on every bit boundary.
  - bit_idx is 3 bits and advances only at a boundary in DATA.
- Parity is computed from the latched byte, never from live P_DATA.

## Timing
- Reset (async, rst=0): state=IDLE, TX_OUT=1, Busy=0, counters=0, latched registers=0. This applies immediately, including mid-frame.
- Acceptance:
  - Data_Valid=1 at edge N in IDLE makes TX_OUT=0 and Busy=1 visible after edge N.
  - Latency is 1 edge; there is no combinational path from input to output.
- Each bit occupies exactly P cycles.
- Frame length:
  - Busy stays high for 10·P cycles without parity and 11·P cycles with parity.
  - Busy falls on the same edge on which the STOP period ends.
- Back-to-back frames:
  - The earliest next acceptance is the edge after Busy falls.
  - TX_OUT therefore shows at least 1 idle cycle of 1 between frames (the stop bit plus that cycle).
- If Data_Valid is held high continuously, frames repeat with exactly 1 idle cycle between them.
- TX_OUT and Busy change only on clock edges (or asynchronously on reset) and are glitch-free.

## Test plan
- Reset mid-frame:
  - Stimulus: assert rst=0 during DATA bit 3, release, then send P_DATA=0x0F, PAR_EN=0, prescale=4.
  - Required: TX_OUT=1 and Busy=0 immediately on reset; the next frame is sent cleanly as 0,1,1,1,1,0,0,0,0,1.
- Even parity:
  - Stimulus: P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, prescale=8.
  - Required: TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1, each held 8 cycles; Busy high for 88 cycles; parity bit=0.
- Odd parity:
  - Stimulus: same as above with PAR_TYP=1.
  - Required: parity bit=1; all other bits unchanged.
- No parity, short bit period:
  - Stimulus: P_DATA=0x80, PAR_EN=0, prescale=1.
  - Required: TX_OUT sequence 0,0,0,0,0,0,0,0,1,1, one cycle each; Busy high for exactly 10 cycles.
- prescale=0 and input changes mid-frame:
  - Stimulus: prescale=0; change P_DATA and pulse Data_Valid mid-frame.
  - Required: behaves as prescale=1; the frame uses the originally latched byte; the mid-frame pulse is dropped.
- Continuous Data_Valid:
  - Stimulus: hold Data_Valid=1 with P_DATA=0x55, PAR_EN=0, prescale=16.
  - Required: consecutive frames separated by exactly 1 cycle of TX_OUT=1 and Busy=0; each frame is 160 cycles long.
